fb_sram_sched: RTL and testbench

Single-clock scheduler that owns the frame-buffer SRAM port and shares it between two requesters. The display prefetch path issues reads; the pixel renderer issues writes. The block also owns the double-buffer select: reads go to the front half of SRAM and writes go to the back half. The halves swap at the first vsync after the renderer reports frame completion.

---
 rtl/fb_sram_sched.sv | 189 ++++++++++++++++++
 tb/tb_fb_sram_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_sram_sched.sv
// Frame-buffer SRAM port scheduler: arbitrates display reads against renderer writes and
// owns the front/back buffer select that swaps on vsync after a completed frame.
module fb_sram_sched #(
  parameter int unsigned ADDR_W       = 19,
  parameter int unsigned RD_CYCLES    = 2,
  parameter int unsigned WR_CYCLES    = 3,
  parameter int unsigned RD_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  output logic              wr_ack,
  input  logic              frame_done,
  input  logic              vsync_start,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_sel,
  output logic [ADDR_W:0]   ram_addr,
  output logic [31:0]       ram_dout,
  output logic              ram_dout_oe,
  input  logic [31:0]       ram_din,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output logic [3:0]        ram_be_n
);

  localparam int unsigned StreakW = $clog2(RD_BURST_MAX + 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [31:0]         dout_q, dout_d;
  logic                ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic                dout_oe_q, dout_oe_d;
  logic                rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d;
  logic                rd_valid_q, rd_valid_d;
  logic [31:0]         rd_data_q, rd_data_d;
  logic                front_q, front_d, pending_q, pending_d, swap_done_q, swap_done_d;
  logic                wr_elig, rd_win;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    dout_oe_d   = dout_oe_q;
    rd_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    front_d     = front_q;
    pending_d   = pending_q;
    swap_done_d = 1'b0;
    // A pending swap freezes the back buffer so the finished frame survives until vsync.
    wr_elig     = wr_req & ~pending_q;
    rd_win      = rd_req & ~(wr_elig & (streak_q == StreakW'(RD_BURST_MAX)));

    unique case (state_q)
      StIdle: begin
        if (rd_win) begin
          state_d  = StRead;
          cnt_d    = 8'd0;
          addr_d   = {front_q, rd_addr};
          ce_n_d   = 1'b0;
          oe_n_d   = 1'b0;
          rd_ack_d = 1'b1;
          streak_d = wr_elig ? streak_q + StreakW'(1) : '0;
        end else if (wr_elig) begin
          state_d   = StWrite;
          cnt_d     = 8'd0;
          addr_d    = {~front_q, wr_addr};
          dout_d    = wr_data;
          ce_n_d    = 1'b0;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          dout_oe_d = 1'b1;
          wr_ack_d  = 1'b1;
          streak_d  = '0;
        end else begin
          streak_d = '0;
        end
      end
      StRead: begin
        if (cnt_q == 8'(RD_CYCLES - 1)) begin
          state_d    = StIdle;
          ce_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          rd_data_d  = ram_din;
          rd_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: begin
        if (cnt_q == 8'(WR_CYCLES - 1)) begin
          state_d   = StIdle;
          ce_n_d    = 1'b1;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          dout_oe_d = 1'b0;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          // First and last write cycles keep we_n high for address/data setup and hold.
          we_n_d = (cnt_d == 8'(WR_CYCLES - 1));
        end
      end
      default: state_d = StIdle;
    endcase

    if (pending_q) begin
      if (vsync_start) begin
        front_d     = ~front_q;
        pending_d   = 1'b0;
        swap_done_d = 1'b1;
      end
    end else if (frame_done) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      streak_q    <= '0;
      addr_q      <= '0;
      dout_q      <= 32'd0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dout_oe_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 32'd0;
      front_q     <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dout_oe_q   <= dout_oe_d;
      rd_ack_q    <= rd_ack_d;
      wr_ack_q    <= wr_ack_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      front_q     <= front_d;
      pending_q   <= pending_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign rd_ack       = rd_ack_q;
  assign wr_ack       = wr_ack_q;
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign swap_pending = pending_q;
  assign swap_done    = swap_done_q;
  assign front_sel    = front_q;
  assign ram_addr     = addr_q;
  assign ram_dout     = dout_q;
  assign ram_dout_oe  = dout_oe_q;
  assign ram_ce_n     = ce_n_q;
  assign ram_oe_n     = oe_n_q;
  assign ram_we_n     = we_n_q;
  assign ram_be_n     = 4'b0000;

endmodule

// File: tb/tb_fb_sram_sched.sv
// Bench for fb_sram_sched: directed scenarios plus random traffic, checked cycle by cycle
// against a transaction-level model of the bus timeline, arbitration and buffer swap.
module tb_fb_sram_sched;

  localparam int unsigned AW  = 19;
  localparam int unsigned RDC = 2;
  localparam int unsigned WRC = 3;
  localparam int unsigned BM  = 8;
  localparam byte LogR = 8'h52;
  localparam byte LogW = 8'h57;

  logic          clk, reset_n;
  logic          rd_req, rd_ack, rd_valid;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          wr_req, wr_ack;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          frame_done, vsync_start, swap_pending, swap_done, front_sel;
  logic [AW:0]   ram_addr;
  logic [31:0]   ram_dout, ram_din;
  logic          ram_dout_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [3:0]    ram_be_n;

  fb_sram_sched #(.ADDR_W(AW), .RD_CYCLES(RDC), .WR_CYCLES(WRC), .RD_BURST_MAX(BM)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .frame_done(frame_done), .vsync_start(vsync_start), .swap_pending(swap_pending),
    .swap_done(swap_done), .front_sel(front_sel),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_dout_oe(ram_dout_oe), .ram_din(ram_din),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram_be_n(ram_be_n)
  );

  function automatic logic [31:0] pat(input logic [AW:0] a);
    return {a[11:0], a} ^ 32'h5AC3_0F96;
  endfunction

  assign ram_din = pat(ram_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Requester queues and observation logs.
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  byte           ack_log[$];
  int            acks_seen, wr_seen;
  logic [AW:0]   last_wr_addr;

  // Model: m_kind 0 = bus idle, 1 = read, 2 = write; m_pos is the 1-based cycle in the access.
  int          m_kind, m_pos, m_streak;
  logic [AW:0] m_addr;
  logic [31:0] m_data, m_rd_data;
  logic        m_valid, m_fm, m_pm, m_sd;

  task automatic model_reset();
    m_kind = 0; m_pos = 0; m_streak = 0; m_addr = '0; m_data = '0; m_rd_data = '0;
    m_valid = 1'b0; m_fm = 1'b0; m_pm = 1'b0; m_sd = 1'b0;
  endtask

  task automatic drive();
    rd_req = (rd_q.size() != 0);
    rd_addr = '0;
    if (rd_q.size() != 0) rd_addr = rd_q[0];
    wr_req = (wa_q.size() != 0);
    wr_addr = '0;
    wr_data = '0;
    if (wa_q.size() != 0) begin
      wr_addr = wa_q[0];
      wr_data = wd_q[0];
    end
  endtask

  task automatic step();
    int          n_kind, n_pos, n_streak;
    logic [AW:0] n_addr;
    logic [31:0] n_data, n_rd_data;
    logic        n_valid, n_fm, n_pm, n_sd, elig;
    n_kind = m_kind; n_pos = m_pos; n_streak = m_streak; n_addr = m_addr; n_data = m_data;
    n_rd_data = m_rd_data; n_valid = 1'b0; n_fm = m_fm; n_pm = m_pm; n_sd = 1'b0;
    if (m_pm) begin
      if (vsync_start) begin n_fm = ~m_fm; n_pm = 1'b0; n_sd = 1'b1; end
    end else if (frame_done) begin
      n_pm = 1'b1;
    end
    if (m_kind != 0) begin
      if (m_pos == ((m_kind == 1) ? int'(RDC) : int'(WRC))) begin
        if (m_kind == 1) begin n_valid = 1'b1; n_rd_data = pat(m_addr); end
        n_kind = 0;
      end else begin
        n_pos = m_pos + 1;
      end
    end else begin
      elig = wr_req && !m_pm;
      if (rd_req && !(elig && m_streak == int'(BM))) begin
        n_kind = 1; n_pos = 1; n_addr = {m_fm, rd_addr};
        n_streak = elig ? m_streak + 1 : 0;
      end else if (elig) begin
        n_kind = 2; n_pos = 1; n_addr = {~m_fm, wr_addr}; n_data = wr_data; n_streak = 0;
      end else begin
        n_streak = 0;
      end
    end
    @(posedge clk);
    #1;
    m_kind = n_kind; m_pos = n_pos; m_streak = n_streak; m_addr = n_addr; m_data = n_data;
    m_rd_data = n_rd_data; m_valid = n_valid; m_fm = n_fm; m_pm = n_pm; m_sd = n_sd;
    frame_done = 1'b0;
    vsync_start = 1'b0;

    chk("strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe},
        {m_kind == 0, m_kind != 1, !(m_kind == 2 && m_pos > 1 && m_pos < int'(WRC)), m_kind == 2});
    chk("pulses", {rd_ack, wr_ack, rd_valid, swap_done},
        {m_kind == 1 && m_pos == 1, m_kind == 2 && m_pos == 1, m_valid, m_sd});
    chk("swap_state", {swap_pending, front_sel}, {m_pm, m_fm});
    chk("rd_data", rd_data, m_rd_data);
    if (m_kind != 0) chk("ram_addr", ram_addr, m_addr);
    if (m_kind == 2) chk("ram_dout", ram_dout, m_data);

    if (rd_ack) ack_log.push_back(LogR);
    if (wr_ack) begin
      ack_log.push_back(LogW);
      last_wr_addr = ram_addr;
      wr_seen++;
    end
    if (rd_ack || wr_ack || rd_valid) acks_seen++;

    if (m_kind == 1 && m_pos == 1 && rd_q.size() != 0) void'(rd_q.pop_front());
    if (m_kind == 2 && m_pos == 1 && wa_q.size() != 0) begin
      void'(wa_q.pop_front());
      void'(wd_q.pop_front());
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((rd_q.size() != 0 || wa_q.size() != 0 || m_kind != 0 || m_valid) && n < budget) begin
      vsync_start = m_pm;
      step();
      n++;
    end
    chk("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  initial begin
    logic [2:0] we_pat, oe_pat;
    byte        exp_log[$];
    int         n;

    reset_n = 1'b0; frame_done = 1'b0; vsync_start = 1'b0;
    acks_seen = 0; wr_seen = 0; last_wr_addr = '1;
    model_reset();
    rd_q.push_back(AW'(20'h00010));
    drive();

    // Reset with a read already requested.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}, 4'b1110);
    chk("reset_swap", {front_sel, swap_pending, swap_done}, 3'b000);
    chk("reset_pulses", {rd_ack, wr_ack, rd_valid}, 3'b000);
    chk("reset_bus", {ram_addr, ram_dout, rd_data}, 84'd0);
    chk("be_n", ram_be_n, 4'b0000);
    reset_n = 1'b1;

    step();
    chk("first_rd_ack", rd_ack, 1'b1);
    chk("first_rd_addr", ram_addr, 20'h00010);
    step();
    step();
    chk("first_rd_valid", rd_valid, 1'b1);
    chk("first_rd_data", rd_data, pat(20'h00010));

    // Single write at the top of the back buffer.
    wa_q.push_back(19'h7FFFF);
    wd_q.push_back(32'h00A1B2C3);
    drive();
    n = 0;
    while (!wr_ack && n < 10) begin step(); n++; end
    chk("wr_ack_seen", wr_ack, 1'b1);
    chk("wr_addr", ram_addr, 20'hFFFFF);
    chk("wr_dout", ram_dout, 32'h00A1B2C3);
    we_pat[2] = ram_we_n; oe_pat[2] = ram_dout_oe;
    step();
    we_pat[1] = ram_we_n; oe_pat[1] = ram_dout_oe;
    step();
    we_pat[0] = ram_we_n; oe_pat[0] = ram_dout_oe;
    chk("we_pattern", we_pat, 3'b101);
    chk("oe_pattern", oe_pat, 3'b111);
    drain(20);

    // Read burst limit against a continuously waiting writer.
    ack_log.delete();
    for (int i = 0; i < 20; i++) rd_q.push_back(AW'(i * 4 + 1));
    for (int i = 0; i < 3; i++) begin
      wa_q.push_back(AW'(19'h40000 + i));
      wd_q.push_back(32'hCAFE_0000 + i);
    end
    drive();
    drain(300);
    for (int b = 0; b < 2; b++) begin
      repeat (8) exp_log.push_back(LogR);
      exp_log.push_back(LogW);
    end
    repeat (4) exp_log.push_back(LogR);
    exp_log.push_back(LogW);
    chk("arb_count", ack_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < ack_log.size(); i++)
      chk("arb_order", ack_log[i], exp_log[i]);

    // Swap: writes blocked while pending, resume into the new back buffer after vsync.
    frame_done = 1'b1;
    step();
    chk("pending_set", swap_pending, 1'b1);
    wa_q.push_back(19'h7FF00); wd_q.push_back(32'h1111_2222);
    wa_q.push_back(19'h00123); wd_q.push_back(32'h3333_4444);
    drive();
    wr_seen = 0;
    repeat (20) step();
    chk("no_write_while_pending", wr_seen, 0);
    vsync_start = 1'b1;
    step();
    chk("swap_taken", {front_sel, swap_done, swap_pending}, 3'b110);
    last_wr_addr = '1;
    drain(30);
    chk("write_to_new_back", last_wr_addr[AW], 1'b0);

    // frame_done and vsync_start together only arm the swap.
    frame_done = 1'b1;
    vsync_start = 1'b1;
    step();
    chk("simul_events", {front_sel, swap_done, swap_pending}, 3'b101);
    step();
    vsync_start = 1'b1;
    step();
    chk("second_vsync", {front_sel, swap_done, swap_pending}, 3'b010);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if (rd_q.size() < 3 && $urandom_range(0, 2) == 0) rd_q.push_back(AW'($urandom));
      if (wa_q.size() < 3 && $urandom_range(0, 3) == 0) begin
        wa_q.push_back(AW'($urandom));
        wd_q.push_back($urandom);
      end
      frame_done = ($urandom_range(0, 39) == 0);
      vsync_start = ($urandom_range(0, 24) == 0);
      drive();
      step();
    end
    frame_done = 1'b0;
    drain(200);

    // Reset during the second write cycle releases the bus at once and loses the access.
    wa_q.push_back(19'h2AAAA);
    wd_q.push_back(32'hDEAD_BEEF);
    drive();
    n = 0;
    while (!(m_kind == 2 && m_pos == 2) && n < 20) begin step(); n++; end
    chk("reached_write_cycle2", {ram_ce_n, ram_we_n}, 2'b00);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_strobes", {ram_ce_n, ram_oe_n, ram_we_n, ram_dout_oe}, 4'b1110);
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    model_reset();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    acks_seen = 0;
    repeat (8) step();
    chk("no_pulse_after_reset", acks_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
